gj_axis_uart_tx_arb: RTL and testbench
======================================

Name: gj_axis_uart_tx_arb

Overview:
- Packet-level round-robin arbiter sharing one UART transmit byte stream among N_SRC AXI-Stream packet sources.
- A grant is held for a whole frame, through tlast.
- After each frame, a programmable idle gap, counted in clk_en bit ticks, is enforced. The far-end receiver's gap-timeout framing then sees clean frame boundaries.
- Sits between the protocol/command sources and the UART serializer in the TX path.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- GAP_W, 16, width of the gap counter and of minTxGap.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  bit-tick strobe from the baud generator; one clk wide
- minTxGap  in  GAP_W  idle clk_en ticks inserted after each frame; 0 means no gap
- s_tvalid  in  N_SRC  per-source valid
- s_tdata  in  8*N_SRC  per-source byte; source i occupies bits [8i+7:8i]
- s_tlast  in  N_SRC  per-source end of frame
- s_tready  out  N_SRC  per-source ready
- tx_tvalid  out  1  byte valid to the serializer
- tx_tdata  out  8  byte to the serializer
- tx_tready  in  1  serializer accepts a byte
- grant_id  out  3  index of the current or last granted source
- busy  out  1  high in SEND or GAP

Behaviour:
- Reset is clk/rst, synchronous, active-high. Reset values:
  - state IDLE, rrPtr 0, grant_id 0, gapCnt 0, busy 0.
  - tx_tvalid 0 and s_tready all 0, because both are combinational from state.
- State IDLE:
  - If any s_tvalid is high, search from index rrPtr upward, modulo N_SRC. The first requester found is the winner.
  - Register the winner in grant_id, set rrPtr = winner+1 (mod N_SRC), go to SEND.
  - Arbitration latency is 1 clk from request to grant. No byte is passed in IDLE.
- State SEND:
  - Combinational pass-through: tx_tvalid = s_tvalid[g], tx_tdata = s_tdata[g], s_tready[g] = tx_tready.
  - All other s_tready are 0.
  - The grant is held while s_tvalid[g] is low mid-frame (no timeout unless the optional feature is compiled in).
  - On tx_tvalid & tx_tready & s_tlast[g]:
    - If minTxGap == 0, go to IDLE.
    - Otherwise load gapCnt = minTxGap and go to GAP.
- State GAP:
  - No transfers; all s_tready are 0 and tx_tvalid is 0.
  - gapCnt decrements on each clk_en.
  - When gapCnt == 1 & clk_en, go to IDLE. Exactly minTxGap ticks are counted from entry.
- Boundary rules:
  - minTxGap is sampled only at load; changes during GAP take effect on the next frame.
  - A single-byte frame (tlast on the first byte) follows the normal SEND→GAP path.
  - Simultaneous requests are resolved by rotating priority. A source that requests continuously cannot starve the others: after N_SRC frames, every requester has been served.
  - rst during SEND or GAP returns to IDLE next clk. The partial frame is truncated, and no tlast is synthesized.
  - s_tdata and s_tlast of non-granted sources are ignored.
- busy = (state != IDLE), registered-state derived.

Optional Feature:
- Macro: GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN.
- With the macro defined:
  - Adds input maxStall [GAP_W-1:0] and output abort_pulse.
  - In SEND, stallCnt is reloaded to maxStall on every accepted byte and decremented on clk_en while s_tvalid[g] is low.
  - When it reaches 0 (and maxStall != 0), abort_pulse is high for 1 clk and the FSM enters GAP as if tlast had occurred. The source is not drained.
- Without the macro: no extra ports, and the grant is held indefinitely.

Decomposition:
- Shared package gj_axis_uart_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_SEND=2'd1, ST_GAP=2'd2.
  - GAP_W default.
  - the grant-index width function clog2.
- One natural sub-module: gj_rr_pick, a combinational rotating-priority encoder (req vector + rrPtr → winner index + found). It can be reused by future RX demux arbitration.

Test Plan:
- Single source 0, 3-byte frame 0x11,0x22,0x33 (tlast on 0x33), tx_tready=1, minTxGap=2 → tx_tdata sequence 11,22,33; busy falls exactly 2 clk_en ticks after the 0x33 handshake; grant_id=0.
- All 4 sources requesting continuously with 1-byte frames, minTxGap=0 → grant_id order 0,1,2,3,0; one frame per source per rotation.
- Source 2 frame with tx_tready toggling 1,0,1,0 → each byte is held stable while tx_tready=0; s_tready[2] mirrors tx_tready; other s_tready stay 0.
- Source 1 deasserts tvalid for 10 clk mid-frame while source 3 requests → grant stays 1 until tlast; source 3 is granted only after the gap.
- rst asserted on the 2nd byte of a 4-byte frame → next clk: busy=0, tx_tvalid=0, grant_id=0; a new request from source 0 is granted first.
- With GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN, maxStall=3, source stalls after byte 1 → abort_pulse 1 clk after the 3rd clk_en; the FSM enters GAP and the next requester is granted afterwards.

Source files
------------

// File: rtl/gj_axis_uart_pkg.sv
// Shared definitions for the UART TX arbiter slice: state encoding, default gap
// width and the index-width helper.
package gj_axis_uart_pkg;

  localparam int GAP_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/gj_rr_pick.sv
// Combinational rotating-priority encoder: returns the first set request at or
// above i_ptr, wrapping modulo N.
module gj_rr_pick
  import gj_axis_uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW:0]    w_sum;

  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_ptr);

  always_comb begin
    o_found = 1'b0;
    w_sum   = '0;
    // Scan downward so the lowest rotated position is the one left standing.
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_found = 1'b1;
        w_sum   = (IW+1)'(i_ptr) + (IW+1)'(j);
      end
    end
    if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
    o_idx = w_sum[IW-1:0];
  end

endmodule

// File: rtl/gj_axis_uart_tx_arb.sv
// Packet-level round-robin arbiter feeding one UART TX byte stream, with an
// idle gap after each frame. Optional stall abort: GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN.
module gj_axis_uart_tx_arb
  import gj_axis_uart_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [GAP_W-1:0]   minTxGap,
  input  logic [N_SRC-1:0]   s_tvalid,
  input  logic [8*N_SRC-1:0] s_tdata,
  input  logic [N_SRC-1:0]   s_tlast,
  output logic [N_SRC-1:0]   s_tready,
  output logic               tx_tvalid,
  output logic [7:0]         tx_tdata,
  input  logic               tx_tready,
  output logic [2:0]         grant_id,
  output logic               busy
`ifdef GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN
  ,
  input  logic [GAP_W-1:0]   maxStall,
  output logic               abort_pulse
`endif
);

  localparam int IW = clog2(N_SRC);

  state_t           r_state, w_next;
  logic [IW-1:0]    r_rr_ptr, r_grant, w_pick;
  logic             w_found;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_g_valid, w_g_last, w_fire, w_end;
  logic [7:0]       w_g_data;

  gj_rr_pick #(.N(N_SRC), .IW(IW)) u_pick (
    .i_req   (s_tvalid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant == IW'(i)) begin
        w_g_valid = s_tvalid[i];
        w_g_last  = s_tlast[i];
        w_g_data  = s_tdata[8*i +: 8];
      end
    end
  end

  assign w_fire = (r_state == ST_SEND) & w_g_valid & tx_tready;

`ifdef GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN
  logic [GAP_W-1:0] r_stall_cnt;
  logic             w_abort;
  assign w_abort     = (r_state == ST_SEND) & ~w_g_valid & (r_stall_cnt == '0) & (maxStall != '0);
  assign w_end       = (w_fire & w_g_last) | w_abort;
  assign abort_pulse = w_abort;
`else
  assign w_end = w_fire & w_g_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_gap_cnt <= '0;
`ifdef GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN
      r_stall_cnt <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant  <= w_pick;
            r_rr_ptr <= (w_pick == IW'(N_SRC - 1)) ? '0 : w_pick + IW'(1);
`ifdef GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN
            r_stall_cnt <= maxStall;
`endif
          end
        end
        ST_SEND: begin
          if (w_end) r_gap_cnt <= minTxGap;
`ifdef GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN
          if (w_fire) r_stall_cnt <= maxStall;
          else if (clk_en && !w_g_valid && r_stall_cnt != '0) r_stall_cnt <= r_stall_cnt - 1'b1;
`endif
        end
        ST_GAP: begin
          if (clk_en) r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_next = ST_SEND;
      ST_SEND: if (w_end) w_next = (minTxGap == '0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (clk_en && r_gap_cnt == GAP_W'(1)) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready  = '0;
    tx_tvalid = 1'b0;
    tx_tdata  = '0;
    if (r_state == ST_SEND) begin
      tx_tvalid = w_g_valid;
      tx_tdata  = w_g_data;
      for (int i = 0; i < N_SRC; i++) begin
        if (r_grant == IW'(i)) s_tready[i] = tx_tready;
      end
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign grant_id = 3'(r_grant);

endmodule

// File: tb/tb_gj_axis_uart_tx_arb.sv
// Self-checking bench for gj_axis_uart_tx_arb: directed scenarios plus randomized
// traffic compared every cycle against a frame-level reference model.
module tb_gj_axis_uart_tx_arb;

  localparam int N  = 4;
  localparam int GW = 16;

  logic            clk = 1'b0;
  logic            rst, clk_en, tx_tready, tx_tvalid, busy;
  logic [GW-1:0]   min_gap;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [8*N-1:0]  s_tdata;
  logic [7:0]      tx_tdata;
  logic [2:0]      grant_id;
`ifdef GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN
  logic [GW-1:0]   max_stall = '0;
  logic            abort_pulse;
`endif

  gj_axis_uart_tx_arb #(.N_SRC(N), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .minTxGap(min_gap),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tready(tx_tready),
    .grant_id(grant_id), .busy(busy)
`ifdef GJ_AXIS_UART_TX_ARB_STALL_TIMEOUT_EN
    , .maxStall(max_stall), .abort_pulse(abort_pulse)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  logic [8:0] src_q [N][$];
  int en_mode [N];
  int p_en = 100, p_rdy = 100, p_clken = 30;
  bit rdy_toggle = 0, rst_k = 0;

  // reference model: who owns the stream, idle ticks still owed, next start index
  int m_owner = -1, m_gap = 0, m_ptr = 0, m_last = 0;

  bit o_hs, o_hs_last, o_clk_en, o_busy, o_tv;
  int o_grant;
  logic [7:0] tx_log [$];
  int gnt_log [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_to(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout, got no event expected event (cycle %0d)", nm, cyc);
  endtask

  task automatic apply();
    logic [8:0] h;
    bit on;
    s_tvalid = '0;
    for (int i = 0; i < N; i++) begin
      s_tdata[8*i +: 8] = 8'($urandom);
      s_tlast[i] = 1'($urandom);
      on = (en_mode[i] == 1) || (en_mode[i] == 2 && $urandom_range(99) < p_en);
      if (on && src_q[i].size() > 0) begin
        h = src_q[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[8*i +: 8] = h[7:0];
        s_tlast[i] = h[8];
      end
    end
    tx_tready = rdy_toggle ? ((cyc % 2) == 0) : ($urandom_range(99) < p_rdy);
    clk_en = ($urandom_range(99) < p_clken);
    rst = rst_k;
  endtask

  task automatic cycle();
    logic e_busy, e_tv;
    logic [N-1:0] e_rdy;
    int win;
    @(negedge clk);
    e_busy = (m_owner >= 0) || (m_gap > 0);
    e_tv = 1'b0;
    e_rdy = '0;
    if (m_owner >= 0) begin
      e_tv = s_tvalid[m_owner];
      e_rdy[m_owner] = tx_tready;
    end
    chk("busy", busy, e_busy);
    chk("tx_tvalid", tx_tvalid, e_tv);
    chk("s_tready", s_tready, e_rdy);
    chk("grant_id", grant_id, m_last);
    if (e_tv) chk("tx_tdata", tx_tdata, s_tdata[8*m_owner +: 8]);

    o_busy = busy; o_tv = tx_tvalid; o_grant = grant_id; o_clk_en = clk_en;
    o_hs = tx_tvalid && tx_tready;
    o_hs_last = o_hs && s_tlast[grant_id];
    if (o_hs) begin
      tx_log.push_back(tx_tdata);
      gnt_log.push_back(int'(grant_id));
    end
    for (int i = 0; i < N; i++)
      if (s_tvalid[i] && s_tready[i]) void'(src_q[i].pop_front());

    if (rst) begin
      m_owner = -1; m_gap = 0; m_ptr = 0; m_last = 0;
    end else if (m_owner >= 0) begin
      if (s_tvalid[m_owner] && tx_tready && s_tlast[m_owner]) begin
        m_gap = int'(min_gap);
        m_owner = -1;
      end
    end else if (m_gap > 0) begin
      if (clk_en) m_gap--;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && s_tvalid[c]) win = c;
      end
      if (win >= 0) begin
        m_owner = win; m_last = win; m_ptr = (win + 1) % N;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    apply();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) src_q[i].delete();
    rst_k = 1; apply(); cycle();
    rst_k = 0; apply();
    tx_log.delete(); gnt_log.delete();
  endtask

  task automatic push_frame(input int src, input int len);
    for (int b = 0; b < len; b++) src_q[src].push_back({(b == len - 1), 8'($urandom)});
  endtask

  task automatic run_until_hs(input int n, input string nm);
    int target;
    bit done;
    target = tx_log.size() + n;
    done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      cycle();
      if (tx_log.size() >= target) done = 1;
    end
    if (!done) fail_to(nm);
  endtask

  int exp_gnt [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [7:0] exp_b [$];
    int ticks, start, phase;
    bit done;
    min_gap = '0;
    for (int i = 0; i < N; i++) en_mode[i] = 1;
    rst_k = 1; apply(); cycle();
    chk("reset_busy", o_busy, 0);
    chk("reset_tvalid", o_tv, 0);
    chk("reset_grant", o_grant, 0);
    do_reset();

    // single source, three bytes, gap of two ticks
    min_gap = 2;
    src_q[0].push_back(9'h011); src_q[0].push_back(9'h022); src_q[0].push_back(9'h133);
    apply();
    phase = 0; ticks = 0; done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      cycle();
      if (phase == 1) begin
        if (!o_busy) done = 1;
        else if (o_clk_en) ticks++;
      end
      if (o_hs_last) phase = 1;
    end
    if (!done) fail_to("t1_gap_end");
    chk("t1_count", tx_log.size(), 3);
    if (tx_log.size() >= 3) begin
      chk("t1_b0", tx_log[0], 8'h11);
      chk("t1_b1", tx_log[1], 8'h22);
      chk("t1_b2", tx_log[2], 8'h33);
      chk("t1_grant", gnt_log[0], 0);
    end
    chk("t1_gap_ticks", ticks, 2);

    // all four sources, one-byte frames, no gap
    do_reset();
    min_gap = 0;
    for (int i = 0; i < N; i++) for (int f = 0; f < 3; f++) push_frame(i, 1);
    apply();
    run_until_hs(5, "t2_frames");
    for (int k = 0; k < 5; k++)
      if (gnt_log.size() > k) chk($sformatf("t2_order%0d", k), gnt_log[k], exp_gnt[k]);

    // source 2 with toggling serializer ready
    do_reset();
    min_gap = 1;
    rdy_toggle = 1;
    push_frame(2, 4);
    exp_b.delete();
    foreach (src_q[2][k]) exp_b.push_back(src_q[2][k][7:0]);
    apply();
    run_until_hs(4, "t3_frame");
    for (int k = 0; k < 4; k++)
      if (tx_log.size() > k) chk($sformatf("t3_b%0d", k), tx_log[k], exp_b[k]);
    rdy_toggle = 0;

    // source 1 stalls mid-frame while source 3 waits
    do_reset();
    min_gap = 3;
    push_frame(1, 4);
    push_frame(3, 2);
    apply();
    run_until_hs(1, "t4_first");
    en_mode[1] = 0; apply();
    for (int t = 0; t < 10; t++) cycle();
    chk("t4_hold_grant", o_grant, 1);
    chk("t4_no_src3", tx_log.size(), 1);
    en_mode[1] = 1; apply();
    run_until_hs(5, "t4_rest");
    if (gnt_log.size() >= 6) begin
      chk("t4_g3", gnt_log[3], 1);
      chk("t4_g4", gnt_log[4], 3);
      chk("t4_g5", gnt_log[5], 3);
    end

    // reset on the second byte of a four-byte frame
    do_reset();
    min_gap = 2;
    push_frame(3, 4);
    apply();
    run_until_hs(1, "t5_first");
    rst_k = 1; apply(); cycle();
    rst_k = 0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    push_frame(0, 2);
    push_frame(3, 2);
    apply(); cycle();
    chk("t5_busy", o_busy, 0);
    chk("t5_tvalid", o_tv, 0);
    chk("t5_grant", o_grant, 0);
    start = gnt_log.size();
    run_until_hs(1, "t5_regrant");
    if (gnt_log.size() > start) chk("t5_first_src", gnt_log[start], 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) en_mode[i] = 2;
    p_en = 70; p_rdy = 70; p_clken = 30;
    min_gap = GW'($urandom_range(3));
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 2) push_frame(i, $urandom_range(1, 4));
      if ($urandom_range(49) == 0) min_gap = GW'($urandom_range(3));
      rst_k = ($urandom_range(599) == 0);
      apply();
      cycle();
    end
    rst_k = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
